// File: rtl/intr_ctrl.sv
// intr_ctrl: memory-mapped interrupt controller. It merges N_SRC edge-triggered
// sources onto the single MCU INTR line. The controller uses fixed priority,
// enables each source separately, needs a software ACK, and then forces a
// holdoff gap before INTR can rise again.

// Per-source slice: it detects a rising edge and keeps the sticky pending bit.
module intr_src_slice (
  input  logic clk_i,
  input  logic rst_i,
  input  logic irq_i,
  input  logic clr_i,
  output logic pend_o
);
  logic irq_q, pend_q, pend_d;

  // A new edge wins over a same-cycle clear (W1C or ACK).
  assign pend_d = (irq_i & ~irq_q) | (pend_q & ~clr_i);
  assign pend_o = pend_q;

  // Remember the previous request level and the pending state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      irq_q  <= irq_i;
      pend_q <= pend_d;
    end
  end
endmodule

module intr_ctrl #(
  parameter int          N_SRC     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h1100E000,
  parameter int          HOLDOFF   = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N_SRC-1:0] IRQ_IN,
  input  logic [31:0]      IOBUS_ADDR,
  input  logic [31:0]      IOBUS_OUT,
  input  logic             IOBUS_WR,
  output logic [31:0]      RDATA,
  output logic             HIT,
  output logic             INTR
);
  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_HOLD} state_e;

  // The ACK transition loads HOLDOFF-1. Because HOLD leaves straight to ASSERT,
  // INTR stays low for exactly HOLDOFF cycles.
  localparam logic [7:0] HOLD_LOAD = 8'(HOLDOFF - 1);

  state_e           state_q;
  logic [7:0]       cnt_q;
  logic             intr_q;
  logic [N_SRC-1:0] en_q;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] clr_vec;
  logic [N_SRC-1:0] act_vec;
  logic             active;
  logic [3:0]       cause_idx;
  logic [1:0]       off;
  logic             we, en_wr, w1c_wr, ack_wr;
  logic [3:0]       ack_id;
  logic [31:0]      rdata;
  logic             unused_wdata;

  // Decode the window. Only word-aligned addresses inside the 16-byte block hit.
  assign HIT    = (IOBUS_ADDR[31:4] == BASE_ADDR[31:4]) && (IOBUS_ADDR[1:0] == 2'b00);
  assign off    = IOBUS_ADDR[3:2];
  assign we     = IOBUS_WR & HIT;
  assign en_wr  = we && (off == 2'd0);
  assign w1c_wr = we && (off == 2'd1);
  assign ack_wr = we && (off == 2'd3);
  assign ack_id = IOBUS_OUT[3:0];

  assign unused_wdata = ^IOBUS_OUT;

  assign act_vec = pend & en_q;
  assign active  = |act_vec;

  // Build the clear mask. An ACK id beyond N_SRC matches no slice.
  always_comb begin
    clr_vec = '0;
    for (int i = 0; i < N_SRC; i++) begin
      clr_vec[i] = (w1c_wr & IOBUS_OUT[i]) | (ack_wr && (ack_id == 4'(i)));
    end
  end

  // Find the lowest-index enabled pending source.
  always_comb begin
    cause_idx = 4'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (act_vec[i]) cause_idx = 4'(i);
    end
  end

  // Read mux: returns zero when the window is not hit and for the ACK register.
  always_comb begin
    rdata = '0;
    if (HIT) begin
      case (off)
        2'd0: rdata[N_SRC-1:0] = en_q;
        2'd1: rdata[N_SRC-1:0] = pend;
        2'd2: begin
          rdata[31]  = active;
          rdata[3:0] = cause_idx;
        end
        default: rdata = '0;
      endcase
    end
  end
  assign RDATA = rdata;

  genvar g;
  generate
    for (g = 0; g < N_SRC; g++) begin : g_src
      intr_src_slice u_src (
        .clk_i  (CLK),
        .rst_i  (RESET),
        .irq_i  (IRQ_IN[g]),
        .clr_i  (clr_vec[g]),
        .pend_o (pend[g])
      );
    end
  endgenerate

  // ENABLE register.
  always_ff @(posedge CLK) begin
    if (RESET)      en_q <= '0;
    else if (en_wr) en_q <= IOBUS_OUT[N_SRC-1:0];
  end

  // INTR handshake FSM with a registered INTR output.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      intr_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (active) begin
            state_q <= S_ASSERT;
            intr_q  <= 1'b1;
          end
        end
        S_ASSERT: begin
          if (ack_wr) begin
            state_q <= S_HOLD;
            cnt_q   <= HOLD_LOAD;
            intr_q  <= 1'b0;
          end else if (!active) begin
            state_q <= S_IDLE;
            intr_q  <= 1'b0;
          end
        end
        S_HOLD: begin
          if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
          end else if (active) begin
            state_q <= S_ASSERT;
            intr_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          intr_q  <= 1'b0;
        end
      endcase
    end
  end

  assign INTR = intr_q;
endmodule

// File: tb/tb_intr_ctrl.sv
// Directed testbench for intr_ctrl. Each expected value is worked out by hand.
module tb_intr_ctrl;
  localparam logic [31:0] BASE = 32'h1100E000;
  localparam logic [31:0] A_EN = BASE + 32'h0;
  localparam logic [31:0] A_PE = BASE + 32'h4;
  localparam logic [31:0] A_CA = BASE + 32'h8;
  localparam logic [31:0] A_AK = BASE + 32'hC;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [3:0]  IRQ_IN;
  logic [31:0] IOBUS_ADDR, IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] RDATA;
  logic        HIT, INTR;

  int n_chk  = 0;
  int n_pass = 0;

  intr_ctrl #(.N_SRC(4), .BASE_ADDR(BASE), .HOLDOFF(8)) dut (
    .CLK(CLK), .RESET(RESET), .IRQ_IN(IRQ_IN),
    .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT), .IOBUS_WR(IOBUS_WR),
    .RDATA(RDATA), .HIT(HIT), .INTR(INTR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    IOBUS_ADDR = a; IOBUS_OUT = d; IOBUS_WR = 1'b1;
    tick();
    IOBUS_WR = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    IOBUS_ADDR = a;
    #1;
    chk(tag, RDATA, exp);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  initial begin
    int low;
    RESET = 1'b1; IRQ_IN = '0; IOBUS_ADDR = '0; IOBUS_OUT = '0; IOBUS_WR = 1'b0;
    tick(); tick();
    RESET = 1'b0;

    // reset state and decode
    chk("rst_intr", {31'b0, INTR}, 32'h0);
    rd("rst_en",    A_EN, 32'h0);
    rd("rst_pend",  A_PE, 32'h0);
    rd("rst_cause", A_CA, 32'h0);
    rd("ack_rd",    A_AK, 32'h0);
    IOBUS_ADDR = A_EN;          #1; chk("hit_lo",   {31'b0, HIT}, 32'h1);
    IOBUS_ADDR = A_AK;          #1; chk("hit_hi",   {31'b0, HIT}, 32'h1);
    IOBUS_ADDR = BASE + 32'h10; #1; chk("hit_past", {31'b0, HIT}, 32'h0);
    chk("rd_past", RDATA, 32'h0);
    IOBUS_ADDR = BASE - 32'h4;  #1; chk("hit_below", {31'b0, HIT}, 32'h0);

    // a single-cycle pulse on source 1
    wr(A_EN, 32'h3);
    rd("en_rb", A_EN, 32'h3);
    IRQ_IN = 4'b0010; tick(); IRQ_IN = '0;
    rd("p1_pend", A_PE, 32'h2);
    chk("p1_intr_lag", {31'b0, INTR}, 32'h0);
    tick();
    chk("p1_intr", {31'b0, INTR}, 32'h1);
    rd("p1_cause", A_CA, 32'h80000001);

    // ACK starts an exact holdoff gap, then INTR re-asserts for the next source
    do_reset();
    wr(A_EN, 32'h6);
    IRQ_IN = 4'b0110; tick(); IRQ_IN = '0;
    tick();
    chk("ho_intr", {31'b0, INTR}, 32'h1);
    rd("ho_cause1", A_CA, 32'h80000001);
    wr(A_AK, 32'h1);
    rd("ho_pend", A_PE, 32'h4);
    low = 0;
    for (int i = 0; i < 20; i++) begin
      if (INTR) break;
      low++;
      tick();
    end
    chk("ho_gap", low, 32'd8);
    chk("ho_reassert", {31'b0, INTR}, 32'h1);
    rd("ho_cause2", A_CA, 32'h80000002);

    // an edge and a W1C in the same cycle: the edge sets the bit
    do_reset();
    IRQ_IN = 4'b0001; tick(); IRQ_IN = '0; tick();
    rd("sw_pre", A_PE, 32'h1);
    IRQ_IN = 4'b0001;
    wr(A_PE, 32'h1);
    IRQ_IN = '0;
    rd("sw_setwins", A_PE, 32'h1);
    wr(A_PE, 32'h1);
    rd("w1c_clr", A_PE, 32'h0);

    // a disabled source still latches; enabling it later raises INTR
    do_reset();
    IRQ_IN = 4'hF; tick(); IRQ_IN = '0; tick(); tick();
    rd("dis_pend", A_PE, 32'hF);
    chk("dis_intr", {31'b0, INTR}, 32'h0);
    rd("dis_cause", A_CA, 32'h0);
    wr(A_EN, 32'h8);
    tick();
    chk("en8_intr", {31'b0, INTR}, 32'h1);
    rd("en8_cause", A_CA, 32'h80000003);

    // a reset during HOLDOFF while source 2 is held high
    wr(A_AK, 32'h3);
    chk("rh_hold", {31'b0, INTR}, 32'h0);
    IRQ_IN = 4'b0100; tick();
    RESET = 1'b1; tick();
    rd("rh_pend0", A_PE, 32'h0);
    rd("rh_en0",   A_EN, 32'h0);
    chk("rh_intr0", {31'b0, INTR}, 32'h0);
    RESET = 1'b0; tick();
    rd("rh_pend4", A_PE, 32'h4);
    tick();
    chk("rh_intr_off", {31'b0, INTR}, 32'h0);
    wr(A_PE, 32'h4);
    tick();
    rd("lvl_once", A_PE, 32'h0);
    IRQ_IN = '0;

    // an out-of-range ACK id still runs the holdoff but clears nothing
    do_reset();
    wr(A_EN, 32'h1);
    IRQ_IN = 4'b0001; tick(); IRQ_IN = '0; tick();
    chk("oor_intr", {31'b0, INTR}, 32'h1);
    wr(A_AK, 32'h7);
    chk("oor_drop", {31'b0, INTR}, 32'h0);
    rd("oor_pend", A_PE, 32'h1);
    for (int i = 0; i < 8; i++) tick();
    chk("oor_reassert", {31'b0, INTR}, 32'h1);
    // disabling the source returns the FSM to IDLE
    wr(A_EN, 32'h0);
    tick();
    chk("dis_idle", {31'b0, INTR}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
